// File: rtl/bnn_dot_seq.sv
// bnn_dot_seq: command-driven sequencer around the BNN CFU-L2 port.
// Streams N operand pairs as CFU requests, sums the returned match counts
// and reports the signed dot product 2*sum - N*DATA_W.
// Optional watchdog: define BNN_DOT_SEQ_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// RUN   | issuing pairs and collecting responses
// DONE  | result presented until res_ready
module bnn_dot_seq #(
   parameter int DATA_W      = 32,
   parameter int LEN_W       = 16,
   parameter int ACC_W       = 24,
   parameter int MAX_OUT     = 4,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   output logic              req_valid,
   input  logic              req_ready,
   output logic [DATA_W-1:0] req_data0,
   output logic [DATA_W-1:0] req_data1,
   input  logic              resp_valid,
   output logic              resp_ready,
   input  logic [1:0]        resp_status,
   input  logic [DATA_W-1:0] resp_data,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [ACC_W-1:0]  res_dot,
   output logic              res_err
);

   localparam int OUT_W = $clog2(MAX_OUT + 1);
   localparam int CNT_W = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

   state_t            state_q, state_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  issued_q, issued_d;
   logic [LEN_W-1:0]  rcvd_q, rcvd_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [OUT_W-1:0]  outst_q, outst_d;
   logic              err_q, err_d;

   logic              can_issue;
   logic              req_fire;
   logic              resp_fire;
   logic              count_oob;
   logic              timeout_hit;
   logic [ACC_W-1:0]  resp_ext;
   logic [ACC_W-1:0]  len_ext;
   logic [ACC_W-1:0]  bias;

   // Handshake qualifiers and datapath outputs
   always_comb begin
      can_issue  = (state_q == ST_RUN) && (issued_q < len_q) &&
                   (outst_q < OUT_W'(MAX_OUT));
      req_valid  = in_valid && can_issue;
      in_ready   = req_ready && can_issue;
      req_fire   = req_valid && req_ready;
      resp_ready = 1'b1;
      resp_fire  = resp_valid;
      cmd_ready  = (state_q == ST_IDLE);
      res_valid  = (state_q == ST_DONE);
      res_err    = (state_q == ST_DONE) ? err_q : 1'b0;
      req_data0  = (state_q == ST_RUN) ? in_a : '0;
      req_data1  = (state_q == ST_RUN) ? in_b : '0;
      // A count above DATA_W can only come from a broken responder; flag it.
      count_oob  = (resp_data > DATA_W'(DATA_W));
      resp_ext   = {{(ACC_W - CNT_W){1'b0}}, resp_data[CNT_W-1:0]};
      len_ext    = {{(ACC_W - LEN_W){1'b0}}, len_q};
      bias       = len_ext * ACC_W'(DATA_W);
      res_dot    = (state_q == ST_DONE) ? ({acc_q[ACC_W-2:0], 1'b0} - bias) : '0;
   end

`ifdef BNN_DOT_SEQ_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

   logic [WD_W-1:0] wd_q, wd_d;

   // Silence watchdog: res_valid appears TIMEOUT_CYC cycles after the last
   // response fire when requests remain outstanding.
   always_comb begin
      wd_d        = wd_q;
      timeout_hit = 1'b0;
      if (state_q == ST_RUN) begin
         if (resp_fire) begin
            wd_d = '0;
         end else if (outst_q != '0) begin
            wd_d = wd_q + 1'b1;
            if (wd_q == WD_W'(TIMEOUT_CYC - 2)) timeout_hit = 1'b1;
         end
      end else begin
         wd_d = '0;
      end
   end

   // Watchdog register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wd_q <= '0;
      else        wd_q <= wd_d;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // Next-state and counter update
   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      issued_d = issued_q;
      rcvd_d   = rcvd_q;
      acc_d    = acc_q;
      outst_d  = outst_q;
      err_d    = err_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               len_d    = cmd_len;
               issued_d = '0;
               rcvd_d   = '0;
               acc_d    = '0;
               outst_d  = '0;
               err_d    = 1'b0;
               state_d  = (cmd_len != '0) ? ST_RUN : ST_DONE;
            end
         end
         ST_RUN: begin
            if (req_fire) issued_d = issued_q + 1'b1;
            if (req_fire && !resp_fire)      outst_d = outst_q + 1'b1;
            else if (!req_fire && resp_fire) outst_d = outst_q - 1'b1;
            if (resp_fire) begin
               acc_d  = acc_q + resp_ext;
               rcvd_d = rcvd_q + 1'b1;
               err_d  = err_q | (resp_status != 2'd0) | count_oob;
               if (rcvd_d == len_q) state_d = ST_DONE;
            end
            if (timeout_hit) begin
               state_d = ST_DONE;
               err_d   = 1'b1;
               outst_d = '0;
            end
         end
         ST_DONE: begin
            if (res_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         len_q    <= '0;
         issued_q <= '0;
         rcvd_q   <= '0;
         acc_q    <= '0;
         outst_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         issued_q <= issued_d;
         rcvd_q   <= rcvd_d;
         acc_q    <= acc_d;
         outst_q  <= outst_d;
         err_q    <= err_d;
      end
   end

endmodule
